multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multi-cycle RV32I core. Sequences the shared datapath (PC, IR, MDR, register file, ALU, unified memory port) one micro-step per clock. Drives the write enables of the 32-bit datapath registers, including the MDR `sign_extend`/`zero_extend` selects for halfword loads. Stalls on a memory ready handshake and traps on unsupported opcodes.

## Interface
- No parameters.
- `clk` in 1 — single system clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `opcode` in 7 — IR[6:0].
- `funct3` in 3 — IR[14:12].
- `zero` in 1 — ALU zero flag.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `mem_req` out 1 — memory access request.
- `mem_we` out 1 — memory write.
- `adr_src` out 1 — address mux: 0 = PC, 1 = ALUOut.
- `pc_we` out 1 — PC write enable.
- `ir_we` out 1 — IR and OldPC write enable.
- `mdr_we` out 1 — MDR write enable.
- `mdr_sext` out 1 — MDR `sign_extend` select.
- `mdr_zext` out 1 — MDR `zero_extend` select.
- `reg_we` out 1 — register file write enable.
- `alu_src_a` out 2 — 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2 — 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op` out 2 — 00 = add, 01 = sub (compare), 10 = decode funct.
- `result_src` out 2 — 00 = ALUOut, 01 = MDR, 10 = ALU result.
- `illegal` out 1 — sticky trap flag.
- `state` out 4 — current state code, for debug.

## Operation
- **State codes:** FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11. Codes 12–15 are unreachable and map to TRAP.
- **Default outputs:** every output not listed for a state is 0.
- **FETCH:** `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10.
  - `ir_we` and `pc_we` equal `mem_ready`.
  - Go to DECODE when `mem_ready`=1; otherwise stay.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01 (computes branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → TRAP
- **MEMADR:** `alu_src_a`=10, `alu_src_b`=01. Go to MEMREAD if opcode=0000011, else MEMWRITE.
- **MEMREAD:** `mem_req`=1, `adr_src`=1.
  - `mdr_we`=`mem_ready`.
  - `mdr_sext`=(`funct3`==001), `mdr_zext`=(`funct3`==101); neither for 010.
  - Go to MEMWB on `mem_ready`; otherwise stay.
- **MEMWB:** `result_src`=01, `reg_we`=1. Go to FETCH.
- **MEMWRITE:** `mem_req`=1, `mem_we`=1, `adr_src`=1. Go to FETCH on `mem_ready`; otherwise stay, holding all outputs.
- **EXECR:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Go to ALUWB.
- **EXECI:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Go to ALUWB.
- **ALUWB:** `result_src`=00, `reg_we`=1. Go to FETCH.
- **BEQ:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_we`=`zero`. Go to FETCH.
- **JAL:** `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_we`=1. Go to ALUWB (writes PC+4 to rd).
- **TRAP:** all enables 0, `illegal`=1. Stays in TRAP until reset.
- **Encoding:** outputs are decoded from `state` plus the `mem_ready`, `zero` and `funct3` gating listed above. Next state is registered.

## Timing
- **Reset:** when `rst`=0 at a rising edge, state becomes FETCH and `illegal` becomes 0.
  - While `rst` is low, all enables (`mem_req`, `mem_we`, `pc_we`, `ir_we`, `mdr_we`, `reg_we`) and `illegal` are forced to 0, regardless of state.
  - Reset mid-access (MEMREAD/MEMWRITE stall) abandons the access; no enable pulses.
- **Cycles per instruction with zero-wait memory:** lw/lh/lhu 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- **Wait states:** each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable except the `mem_ready`-gated enables.
- **Write-enable pulses:** `pc_we`, `ir_we`, `mdr_we` and `reg_we` each pulse for exactly one cycle per use, never across a stall.
- **Branch decision:** `zero` is sampled only in BEQ. Branch taken or not, BEQ takes exactly 1 cycle.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `mem_ready`=1 → `state`=0 and all enables 0 throughout. First cycle after release: `ir_we`=`pc_we`=1.
- **Loads:** lw (`funct3`=010), lh (001), lhu (101), zero-wait → states 0,1,2,3,4. `mdr_sext`/`mdr_zext` = 0/0, 1/0, 0/1 respectively, in MEMREAD with `mdr_we`=1. `reg_we`=1 in state 4 only.
- **Stalled store:** sw with `mem_ready` low for 3 cycles in MEMWRITE → state held at 5 for 4 cycles with `mem_we`=1. Returns to 0; `reg_we` never asserted.
- **Branch:** beq with `zero`=1 → `pc_we`=1 in state 9. With `zero`=0 → `pc_we`=0. Both cases return to FETCH after 3 cycles total.
- **JAL / R-type:** jal → states 0,1,10,8 with `pc_we`=1 in 10 and `reg_we`=1 in 8. R-type → 0,1,6,8 with `alu_op`=10 in state 6.
- **Illegal opcode:** opcode 1111111 → TRAP (11), `illegal`=1 held for 10+ cycles with no enables. Then `rst`=0 for one edge → `state`=0, `illegal`=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: one datapath micro-step per clock,
// stalling on the memory ready handshake and trapping on unsupported opcodes.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       mdr_sext,
    output logic       mdr_zext,
    output logic       reg_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StTrap     = 4'd11
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        mdr_sext   = 1'b0;
        mdr_zext   = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_we      = mem_ready;
                pc_we      = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // ALU precomputes OldPC + imm as the branch target
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                mem_req  = 1'b1;
                adr_src  = 1'b1;
                mdr_we   = mem_ready;
                mdr_sext = (funct3 == 3'b001);
                mdr_zext = (funct3 == 3'b101);
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_we     = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StBeq: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_we     = zero;
                state_d   = StFetch;
            end
            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we     = 1'b1;
                state_d   = StAluWb;
            end
            default: begin
                // StTrap and the unused codes 12-15
                illegal = 1'b1;
                state_d = StTrap;
            end
        endcase

        // Reset abandons any access in flight: no enable may pulse while held
        if (!rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            mdr_we  = 1'b0;
            reg_we  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: walks each instruction class
// through its state sequence and checks state, enables and mux selects every cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, pc_we, ir_we, mdr_we, mdr_sext, mdr_zext;
    logic       reg_we, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_controller dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .adr_src   (adr_src),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .mdr_we    (mdr_we),
        .mdr_sext  (mdr_sext),
        .mdr_zext  (mdr_zext),
        .reg_we    (reg_we),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .result_src(result_src),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Enable bundle: {mem_req, mem_we, pc_we, ir_we, mdr_we, reg_we, illegal}
    localparam logic [6:0] E_NONE  = 7'b0000000;
    localparam logic [6:0] E_FETCH = 7'b1011000;
    localparam logic [6:0] E_FSTL  = 7'b1000000;
    localparam logic [6:0] E_RD    = 7'b1000100;
    localparam logic [6:0] E_RDSTL = 7'b1000000;
    localparam logic [6:0] E_WB    = 7'b0000010;
    localparam logic [6:0] E_WR    = 7'b1100000;
    localparam logic [6:0] E_PC    = 7'b0010000;
    localparam logic [6:0] E_TRAP  = 7'b0000001;

    // Mux bundle: {adr_src, alu_src_a, alu_src_b, alu_op, result_src, mdr_sext, mdr_zext}
    localparam logic [10:0] M_FETCH = 11'b0_00_10_00_10_0_0;
    localparam logic [10:0] M_DEC   = 11'b0_01_01_00_00_0_0;
    localparam logic [10:0] M_MADR  = 11'b0_10_01_00_00_0_0;
    localparam logic [10:0] M_RDW   = 11'b1_00_00_00_00_0_0;
    localparam logic [10:0] M_RDH   = 11'b1_00_00_00_00_1_0;
    localparam logic [10:0] M_RDHU  = 11'b1_00_00_00_00_0_1;
    localparam logic [10:0] M_MWB   = 11'b0_00_00_00_01_0_0;
    localparam logic [10:0] M_WR    = 11'b1_00_00_00_00_0_0;
    localparam logic [10:0] M_EXR   = 11'b0_10_00_10_00_0_0;
    localparam logic [10:0] M_EXI   = 11'b0_10_01_10_00_0_0;
    localparam logic [10:0] M_AWB   = 11'b0_00_00_00_00_0_0;
    localparam logic [10:0] M_BEQ   = 11'b0_10_00_01_00_0_0;
    localparam logic [10:0] M_JAL   = 11'b0_01_10_00_00_0_0;
    localparam logic [10:0] M_TRAP  = 11'b0_00_00_00_00_0_0;

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Settle inputs, check the current cycle's outputs, then advance one clock.
    task automatic step(input string tag, input logic [3:0] st, input logic [6:0] en,
                        input logic [10:0] mx);
        #1;
        chk({tag, ".state"}, {7'd0, state}, {7'd0, st});
        chk({tag, ".en"}, {4'd0, mem_req, mem_we, pc_we, ir_we, mdr_we, reg_we, illegal},
            {4'd0, en});
        chk({tag, ".mux"}, {adr_src, alu_src_a, alu_src_b, alu_op, result_src, mdr_sext,
            mdr_zext}, mx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        opcode    = 7'b0000011;
        funct3    = 3'b010;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: FETCH, no enables even though mem_ready=1
        for (int i = 0; i < 3; i++) step("reset", 4'd0, E_NONE, M_FETCH);
        rst = 1'b1;

        // lw / lh / lhu, zero-wait
        step("lw.f", 4'd0, E_FETCH, M_FETCH);
        step("lw.d", 4'd1, E_NONE, M_DEC);
        step("lw.a", 4'd2, E_NONE, M_MADR);
        step("lw.r", 4'd3, E_RD, M_RDW);
        step("lw.w", 4'd4, E_WB, M_MWB);
        funct3 = 3'b001;
        step("lh.f", 4'd0, E_FETCH, M_FETCH);
        step("lh.d", 4'd1, E_NONE, M_DEC);
        step("lh.a", 4'd2, E_NONE, M_MADR);
        step("lh.r", 4'd3, E_RD, M_RDH);
        step("lh.w", 4'd4, E_WB, M_MWB);
        funct3 = 3'b101;
        step("lhu.f", 4'd0, E_FETCH, M_FETCH);
        step("lhu.d", 4'd1, E_NONE, M_DEC);
        step("lhu.a", 4'd2, E_NONE, M_MADR);
        // One wait state in MEMREAD: mdr_we must wait for ready
        mem_ready = 1'b0;
        step("lhu.rs", 4'd3, E_RDSTL, M_RDHU);
        mem_ready = 1'b1;
        step("lhu.r", 4'd3, E_RD, M_RDHU);
        step("lhu.w", 4'd4, E_WB, M_MWB);

        // Stalled store, also one stalled fetch
        opcode = 7'b0100011;
        funct3 = 3'b010;
        mem_ready = 1'b0;
        step("sw.fs", 4'd0, E_FSTL, M_FETCH);
        mem_ready = 1'b1;
        step("sw.f", 4'd0, E_FETCH, M_FETCH);
        step("sw.d", 4'd1, E_NONE, M_DEC);
        step("sw.a", 4'd2, E_NONE, M_MADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("sw.ws", 4'd5, E_WR, M_WR);
        mem_ready = 1'b1;
        step("sw.w", 4'd5, E_WR, M_WR);

        // beq taken then not taken
        opcode = 7'b1100011;
        zero   = 1'b1;
        step("beqt.f", 4'd0, E_FETCH, M_FETCH);
        step("beqt.d", 4'd1, E_NONE, M_DEC);
        step("beqt.b", 4'd9, E_PC, M_BEQ);
        zero = 1'b0;
        step("beqn.f", 4'd0, E_FETCH, M_FETCH);
        step("beqn.d", 4'd1, E_NONE, M_DEC);
        step("beqn.b", 4'd9, E_NONE, M_BEQ);

        // jal
        opcode = 7'b1101111;
        step("jal.f", 4'd0, E_FETCH, M_FETCH);
        step("jal.d", 4'd1, E_NONE, M_DEC);
        step("jal.j", 4'd10, E_PC, M_JAL);
        step("jal.w", 4'd8, E_WB, M_AWB);

        // R-type and I-type
        opcode = 7'b0110011;
        step("r.f", 4'd0, E_FETCH, M_FETCH);
        step("r.d", 4'd1, E_NONE, M_DEC);
        step("r.x", 4'd6, E_NONE, M_EXR);
        step("r.w", 4'd8, E_WB, M_AWB);
        opcode = 7'b0010011;
        step("i.f", 4'd0, E_FETCH, M_FETCH);
        step("i.d", 4'd1, E_NONE, M_DEC);
        step("i.x", 4'd7, E_NONE, M_EXI);
        step("i.w", 4'd8, E_WB, M_AWB);

        // Reset during a stalled store: access abandoned, no enables
        opcode = 7'b0100011;
        step("swr.f", 4'd0, E_FETCH, M_FETCH);
        step("swr.d", 4'd1, E_NONE, M_DEC);
        step("swr.a", 4'd2, E_NONE, M_MADR);
        mem_ready = 1'b0;
        step("swr.ws", 4'd5, E_WR, M_WR);
        rst = 1'b0;
        mem_ready = 1'b1;
        step("swr.rst", 4'd5, E_NONE, M_WR);
        rst = 1'b1;

        // Illegal opcode: trap is sticky until reset
        opcode = 7'b1111111;
        step("ill.f", 4'd0, E_FETCH, M_FETCH);
        step("ill.d", 4'd1, E_NONE, M_DEC);
        for (int i = 0; i < 11; i++) begin
            mem_ready = i[0];
            zero      = i[1];
            step("ill.trap", 4'd11, E_TRAP, M_TRAP);
        end
        mem_ready = 1'b1;
        rst = 1'b0;
        step("ill.rst", 4'd11, E_NONE, M_TRAP);
        rst = 1'b1;
        opcode = 7'b0110011;
        step("ill.after", 4'd0, E_FETCH, M_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
